// File: rtl/switch_conditioner.sv
// switch_conditioner: per-channel synchronizer, debouncer and press/auto-repeat pulse generator
module switch_conditioner #(
    parameter int N = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 10_000_000,
    parameter logic [N-1:0] REPEAT_MASK = N'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_level,
    output logic [N-1:0] sw_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic s1_q, s2_q, lvl_q, lvl_d, press_q, rise, fall;
        logic [CW-1:0] cnt_q;
        logic [TW-1:0] tmr_q;
        state_t st_q;
        always_comb begin
            lvl_d = (s2_q != lvl_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? s2_q : lvl_q;
            rise = lvl_d & ~lvl_q;
            fall = lvl_q & ~lvl_d;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
                lvl_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q <= sw_raw[i];
                s2_q <= s1_q;
                lvl_q <= lvl_d;
                cnt_q <= (s2_q == lvl_q || cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
            end
        end
        // Pulses are issued on the same edge the debounced level rises, so both outputs align.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q <= IDLE;
                tmr_q <= '0;
                press_q <= 1'b0;
            end else begin
                press_q <= 1'b0;
                if (fall) begin
                    st_q <= IDLE;
                    tmr_q <= '0;
                end else begin
                    case (st_q)
                        IDLE: if (rise) begin
                            press_q <= 1'b1;
                            tmr_q <= '0;
                            st_q <= DELAY;
                        end
                        DELAY: if (REPEAT_MASK[i]) begin
                            if (tmr_q == TW'(REPEAT_DELAY_CYCLES - 1)) begin
                                press_q <= 1'b1;
                                tmr_q <= '0;
                                st_q <= REPEAT;
                            end else begin
                                tmr_q <= tmr_q + 1'b1;
                            end
                        end
                        REPEAT: begin
                            press_q <= tmr_q == TW'(REPEAT_PERIOD_CYCLES - 1);
                            tmr_q <= (tmr_q == TW'(REPEAT_PERIOD_CYCLES - 1)) ? '0 : tmr_q + 1'b1;
                        end
                        default: st_q <= IDLE;
                    endcase
                end
            end
        end
        assign sw_level[i] = lvl_q;
        assign sw_press[i] = press_q;
    end
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed cycle-by-cycle checks of debounce, press and auto-repeat timing
module tb_switch_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] sw_raw = 2'b00;
    logic [1:0] sw_level, sw_press;
    int errors = 0;
    int checks = 0;

    switch_conditioner #(
        .N(2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY_CYCLES(10),
        .REPEAT_PERIOD_CYCLES(3),
        .REPEAT_MASK(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .sw_level(sw_level),
        .sw_press(sw_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected press pattern for an auto-repeating channel whose level rose at cycle t0.
    function automatic logic rep(input int k, input int t0);
        return k == t0 || (k >= t0 + 10 && (k - t0 - 10) % 3 == 0);
    endfunction

    task automatic expect_out(input string tag, input logic [1:0] lvl, input logic [1:0] prs);
        check(tag, {28'd0, sw_level, sw_press}, {28'd0, lvl, prs});
    endtask

    task automatic settle(input string tag);
        sw_raw = 2'b00;
        repeat (12) tick();
        expect_out(tag, 2'b00, 2'b00);
    endtask

    initial begin
        repeat (2) tick();
        expect_out("reset", 2'b00, 2'b00);
        rst = 1'b0;
        tick();
        expect_out("post_reset", 2'b00, 2'b00);

        // Clean press, release timed so the fall lands on a due repeat edge (cycle 31).
        sw_raw = 2'b01;
        for (int k = 1; k <= 36; k++) begin
            tick();
            expect_out($sformatf("clean_k%0d", k), {1'b0, k >= 6 && k < 31}, {1'b0, k < 31 && rep(k, 6)});
            if (k == 25) sw_raw = 2'b00;
        end

        // Re-press after boundary release, with bounce: final rise driven at k=4.
        for (int k = 0; k <= 26; k++) begin
            if (k <= 4) sw_raw = (k % 2 == 0) ? 2'b01 : 2'b00;
            if (k == 18) sw_raw = 2'b00;
            if (k > 0) expect_out($sformatf("bounce_k%0d", k), {1'b0, k >= 10 && k < 24}, {1'b0, k == 10 || k == 20 || k == 23});
            tick();
        end
        settle("idle_after_bounce");

        // Channel 1 has no auto-repeat.
        sw_raw = 2'b10;
        for (int k = 1; k <= 50; k++) begin
            tick();
            expect_out($sformatf("norep_k%0d", k), {k >= 6 && k < 46, 1'b0}, {k == 6, 1'b0});
            if (k == 40) sw_raw = 2'b00;
        end
        settle("idle_after_norep");

        // Reset while repeating with the switch held; held switch counts as a new press.
        sw_raw = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            expect_out($sformatf("prerst_k%0d", k), {1'b0, k >= 6}, {1'b0, rep(k, 6)});
        end
        rst = 1'b1;
        tick();
        expect_out("in_reset", 2'b00, 2'b00);
        rst = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            tick();
            expect_out($sformatf("postrst_j%0d", j), {1'b0, j >= 6}, {1'b0, rep(j, 6)});
        end
        settle("idle_after_rst");

        // Simultaneous press on both channels.
        sw_raw = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            tick();
            expect_out($sformatf("both_k%0d", k), {k >= 6, k >= 6}, {k == 6, rep(k, 6)});
        end
        settle("idle_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 SHALL have parameter N, default 2, meaning the number of independent switch channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (10 ms at 100 MHz), meaning the stable-input period required before the debounced level changes.
REQ-003 SHALL have parameter REPEAT_DELAY_CYCLES, default 50_000_000 (0.5 s), meaning the hold time from press pulse to first auto-repeat pulse.
REQ-004 SHALL have parameter REPEAT_PERIOD_CYCLES, default 10_000_000 (0.1 s), meaning the spacing between subsequent auto-repeat pulses.
REQ-005 SHALL have parameter REPEAT_MASK, default N'b01, where bit i = 1 enables auto-repeat on channel i.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port sw_raw, input, N bits: asynchronous, bouncing switch levels; 1 means pressed.
REQ-009 SHALL have port sw_level, output, N bits: the debounced level per channel.
REQ-010 SHALL have port sw_press, output, N bits: a one-cycle pulse per press event or auto-repeat event; it feeds the wall-clock adjustment inputs (bit 1 = next, bit 0 = increment).

Function
REQ-011 SHALL pass each sw_raw bit through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-012 SHALL give each channel an independent debounce counter sized $clog2(DEBOUNCE_CYCLES+1):
  - s2 == sw_level: counter cleared.
  - s2 != sw_level: counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and s2 != sw_level: sw_level <= s2, counter cleared.
REQ-013 SHALL update sw_level exactly DEBOUNCE_CYCLES+2 rising edges after sw_raw settles; any reversion of s2 before that restarts the count from 0.
REQ-014 SHALL run a per-channel FSM with states IDLE, DELAY and REPEAT, and a timer sized for max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES).
REQ-015 In IDLE, on the edge where sw_level rises 0->1, SHALL assert sw_press[i] for exactly one cycle.
  - REPEAT_MASK[i] = 1: clear the timer and go to DELAY.
  - REPEAT_MASK[i] = 0: remain in DELAY indefinitely with the timer frozen, so no repeats occur.
REQ-016 In DELAY, SHALL increment the timer each cycle; on the edge where timer == REPEAT_DELAY_CYCLES-1, SHALL pulse sw_press[i], clear the timer and go to REPEAT.
REQ-017 In REPEAT, SHALL increment the timer each cycle; on the edge where timer == REPEAT_PERIOD_CYCLES-1, SHALL pulse sw_press[i] and clear the timer.
REQ-018 On the edge where sw_level falls 1->0 in any state, SHALL go to IDLE with the timer cleared and SHALL NOT pulse sw_press that cycle, even if a repeat was due.
REQ-019 SHALL keep sw_press[i] high for at most one cycle per event, never two consecutive cycles; minimum pulse spacing is min(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES).
REQ-020 SHALL keep channels fully independent; simultaneous presses on several channels pulse in the same cycle.
REQ-021 SHALL register sw_level and sw_press directly, with no combinational path from sw_raw to any output.
REQ-022 SHALL accept parameter values >= 2 for all cycle parameters; behaviour below 2 is unsupported.

Reset
REQ-023 While rst = 1 at a clock edge, SHALL clear s1, s2, sw_level, sw_press, all counters and timers, and set every FSM to IDLE.
REQ-024 SHALL abort an in-progress debounce or repeat sequence on rst asserted mid-operation, with no pulse in the reset cycle.
REQ-025 If sw_raw[i] = 1 when rst deasserts, SHALL treat it as a new press: sw_level rises after DEBOUNCE_CYCLES+2 cycles, with one sw_press pulse.

Verification
All scenarios use DEBOUNCE_CYCLES = 4, REPEAT_DELAY_CYCLES = 10, REPEAT_PERIOD_CYCLES = 3, N = 2, REPEAT_MASK = 2'b01.
REQ-026 Clean press: sw_raw[0] 0->1 held -> sw_level[0] rises 6 cycles later; sw_press[0] pulses that cycle, then at +10, +13 and +16 cycles.
REQ-027 Bounce: sw_raw[0] toggles 1,0,1,0 on consecutive cycles, then holds 1 -> no sw_level change until 6 cycles after the final rise; exactly one press pulse.
REQ-028 No-repeat channel: sw_raw[1] held 40 cycles -> exactly one sw_press[1] pulse; sw_level[1] high throughout; release -> sw_level[1] falls 6 cycles later, with no pulse.
REQ-029 Release at repeat boundary: release timed so the sw_level fall coincides with a due repeat edge -> no pulse; FSM in IDLE; a re-press behaves as in REQ-026.
REQ-030 Reset mid-REPEAT: rst pulsed one cycle while sw_raw[0] is held -> all outputs 0 the next cycle; sw_level[0] and sw_press[0] return 6 cycles after rst falls.
REQ-031 Simultaneous press: both sw_raw bits rise in the same cycle -> both sw_press bits pulse in the same cycle; only bit 0 repeats.
